// File: rtl/move_key_debouncer.sv
// Debounces the four direction buttons, turns each clean 0->1 edge into a
// one-cycle press pulse, and holds one encoded move in a valid/ready slot
// until the game-logic FSM takes it.
module move_key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] btn_sync,
   output logic [3:0] btn_level,
   output logic [3:0] btn_press,
   output logic       move_valid,
   output logic [1:0] move_dir,
   input  logic       move_ready,
   output logic       move_drop
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       level_q, level_d;
   logic [3:0]       press_q, press_d;
   logic [1:0]       dir_q, dir_d;
   logic             drop_q, drop_d;

   // Lowest set index wins when several presses arrive together.
   function automatic logic [1:0] lowest_index(input logic [3:0] v);
      logic [1:0] idx;
      if (v[0])      idx = 2'd0;
      else if (v[1]) idx = 2'd1;
      else if (v[2]) idx = 2'd2;
      else           idx = 2'd3;
      return idx;
   endfunction

   // True when more than one bit is set, i.e. some press must be thrown away.
   function automatic logic more_than_one(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

   // Per-channel stability counters: a new level is accepted only after it
   // has differed from the debounced level for DEBOUNCE_CYCLES edges in a row.
   always_comb begin
      level_d = level_q;
      press_d = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (btn_sync[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = btn_sync[i];
            press_d[i] = btn_sync[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Move slot: capture in IDLE, hold while the consumer stalls, and allow a
   // fresh capture on the same cycle the previous move is accepted.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|press_q) begin
               state_d = PENDING;
               dir_d   = lowest_index(press_q);
               drop_d  = more_than_one(press_q);
            end
         end
         PENDING: begin
            if (!move_ready) begin
               drop_d = |press_q;
            end else if (|press_q) begin
               state_d = PENDING;
               dir_d   = lowest_index(press_q);
               drop_d  = more_than_one(press_q);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register for counters, levels, pulses and the move slot.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         level_q <= 4'b0000;
         press_q <= 4'b0000;
         state_q <= IDLE;
         dir_q   <= 2'd0;
         drop_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         level_q <= level_d;
         press_q <= press_d;
         state_q <= state_d;
         dir_q   <= dir_d;
         drop_q  <= drop_d;
      end
   end

   assign btn_level  = level_q;
   assign btn_press  = press_q;
   assign move_valid = (state_q == PENDING);
   assign move_dir   = dir_q;
   assign move_drop  = drop_q;

endmodule

// File: tb/tb_move_key_debouncer.sv
// Directed bench for move_key_debouncer with an 8-cycle debounce window.
module tb_move_key_debouncer;

   logic       Clk;
   logic       Reset;
   logic [3:0] btn_sync;
   logic [3:0] btn_level;
   logic [3:0] btn_press;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       move_ready;
   logic       move_drop;

   int total;
   int bad;

   move_key_debouncer #(.DEBOUNCE_CYCLES(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .btn_sync   (btn_sync),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .move_valid (move_valid),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .move_drop  (move_drop)
   );

   // Free-running 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Advance n rising edges, landing 1 ns after the last one.
   task automatic advance(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check_value(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_output(input string tag, input logic [3:0] e_level,
                               input logic [3:0] e_press, input logic e_valid,
                               input logic [1:0] e_dir, input logic e_drop);
      check_value({tag, ".level"}, btn_level, e_level);
      check_value({tag, ".press"}, btn_press, e_press);
      check_value({tag, ".valid"}, {3'b000, move_valid}, {3'b000, e_valid});
      check_value({tag, ".dir"},   {2'b00, move_dir},    {2'b00, e_dir});
      check_value({tag, ".drop"},  {3'b000, move_drop},  {3'b000, e_drop});
   endtask

   // Linear directed sequence; each check reflects state after the last edge.
   initial begin
      total      = 0;
      bad        = 0;
      Reset      = 1'b0;
      btn_sync   = 4'b0000;
      move_ready = 1'b0;

      // Reset and quiet idle
      advance(3);
      check_output("reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
      Reset = 1'b1;
      advance(20);
      check_output("idle", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

      // Single press on left, stall, then accept
      btn_sync = 4'b0100;
      advance(7);
      check_output("left_e7", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
      advance(1);
      check_output("left_e8", 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0);
      advance(1);
      check_output("left_valid", 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
      advance(5);
      check_output("left_stall", 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
      move_ready = 1'b1;
      advance(1);
      check_output("left_accept", 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
      move_ready = 1'b0;
      btn_sync   = 4'b0000;
      advance(8);
      check_output("left_release", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);

      // Bouncing up button never settles long enough
      btn_sync = 4'b0001;
      advance(5);
      btn_sync = 4'b0000;
      advance(1);
      btn_sync = 4'b0001;
      advance(5);
      check_output("bounce_mid", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);
      btn_sync = 4'b0000;
      advance(10);
      check_output("bounce_end", 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);

      // Simultaneous down and right: lowest index wins, the other is dropped
      btn_sync = 4'b1010;
      advance(8);
      check_output("dual_press", 4'b1010, 4'b1010, 1'b0, 2'd2, 1'b0);
      advance(1);
      check_output("dual_valid", 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b1);
      advance(1);
      check_output("dual_after", 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b0);

      // Press while stalled is dropped, move_dir unchanged
      btn_sync = 4'b1011;
      advance(8);
      check_output("stall_press", 4'b1011, 4'b0001, 1'b1, 2'd1, 1'b0);
      advance(1);
      check_output("stall_drop", 4'b1011, 4'b0000, 1'b1, 2'd1, 1'b1);
      advance(1);
      check_output("stall_after", 4'b1011, 4'b0000, 1'b1, 2'd1, 1'b0);

      // Re-press right so its pulse coincides with move_ready
      btn_sync = 4'b0011;
      advance(8);
      check_output("right_release", 4'b0011, 4'b0000, 1'b1, 2'd1, 1'b0);
      btn_sync = 4'b1011;
      advance(8);
      check_output("right_press", 4'b1011, 4'b1000, 1'b1, 2'd1, 1'b0);
      move_ready = 1'b1;
      advance(1);
      check_output("b2b_capture", 4'b1011, 4'b0000, 1'b1, 2'd3, 1'b0);
      move_ready = 1'b0;
      advance(1);
      check_output("b2b_hold", 4'b1011, 4'b0000, 1'b1, 2'd3, 1'b0);

      // Reset mid-debounce and mid-pending, buttons held through it
      btn_sync = 4'b1010;
      advance(5);
      check_output("pre_reset", 4'b1011, 4'b0000, 1'b1, 2'd3, 1'b0);
      Reset = 1'b0;
      #1;
      check_output("async_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
      advance(2);
      check_output("in_reset", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
      Reset = 1'b1;
      advance(7);
      check_output("held_e7", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
      advance(1);
      check_output("held_e8", 4'b1010, 4'b1010, 1'b0, 2'd0, 1'b0);
      advance(1);
      check_output("held_valid", 4'b1010, 4'b0000, 1'b1, 2'd1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/move_key_debouncer.md
Name: move_key_debouncer

Overview:
- Consumes the four already-synchronized direction-button levels from the upstream synchronizer stage.
- Per channel, a stability counter rejects contact bounce and produces a clean debounced level plus a one-cycle press pulse.
- Presses are encoded into a 2-bit move command and held in a one-entry valid/ready slot until the 2048 game-logic FSM accepts it.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a new input level must persist before it is accepted (10 ms at 50 MHz); legal range ≥2.
CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; derived, not overridden.

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
btn_sync  input  4  synchronized raw button levels; [0]=up, [1]=down, [2]=left, [3]=right; 1=pressed
btn_level  output  4  debounced button levels
btn_press  output  4  one-cycle pulse per channel on debounced 0->1
move_valid  output  1  move command pending
move_dir  output  2  0=up, 1=down, 2=left, 3=right; stable while move_valid=1
move_ready  input  1  consumer accepts the move on a cycle where move_valid & move_ready
move_drop  output  1  one-cycle pulse: at least one press discarded this cycle

Behaviour:
- Reset (Reset=0, async): btn_level=0, btn_press=0, cnt[i]=0, move_valid=0, move_dir=0, move_drop=0, FSM=IDLE.
- Per channel i, each edge:
  - btn_sync[i]==btn_level[i]: cnt[i] <= 0.
  - else if cnt[i]==DEBOUNCE_CYCLES-1: btn_level[i] <= btn_sync[i]; cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- Debounce latency: input differs on edges 1..DEBOUNCE_CYCLES → btn_level changes after edge DEBOUNCE_CYCLES.
- Any single-cycle return to the old level restarts the count from 0.
- Release uses the same rule and has no pulse.
- btn_press[i] is registered. It is 1 for exactly the cycle in which btn_level[i] first reads 1, and 0 otherwise.
- FSM states: IDLE, PENDING. move_valid = (state==PENDING).
  - IDLE: if any btn_press, capture dir = lowest set index → PENDING. Otherwise stay in IDLE.
  - PENDING, move_ready=0: hold move_dir. Any btn_press this cycle is discarded and move_drop=1 next cycle.
  - PENDING, move_ready=1, no press: → IDLE. move_valid=0 next cycle.
  - PENDING, move_ready=1, press present: accept the current move and capture the new one (lowest index). Stay in PENDING, so there are back-to-back valid cycles with the new move_dir.
- Simultaneous presses on multiple channels when a capture occurs: the lowest index is captured, the rest are discarded, and move_drop=1.
- move_drop, btn_press and move_valid are registered outputs with no combinational path from inputs.
- Latency from the btn_press cycle to move_valid=1 is one cycle.
- move_ready while move_valid=0 is ignored.
- Reset asserted mid-count or mid-PENDING: all state clears immediately and the pending move is lost without move_drop.
- Button held through reset release: btn_level starts at 0, so a press is generated DEBOUNCE_CYCLES cycles after reset release.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Test Plan (DEBOUNCE_CYCLES=8):
- Reset low 3 cycles, then high → all outputs 0; btn_sync=0 for 20 cycles → outputs stay 0.
- btn_sync[2]=1 steady → btn_level[2]=1 after edge 8; btn_press[2]=1 for that one cycle only; move_valid=1 next cycle with move_dir=2. Hold move_ready=0 for 5 cycles → move_dir stays 2. Then move_ready=1 for 1 cycle → move_valid=0.
- btn_sync[0] toggles 1 for 5 cycles, 0 for 1, 1 for 5, then 0 → btn_level[0] never rises; no press, no move.
- btn_sync[1] and [3] rise on the same cycle → after 8 cycles, move_dir=1, move_valid=1, move_drop=1 for one cycle.
- While PENDING with move_ready=0, a press on channel 0 → move_drop pulse and move_dir unchanged. Press on channel 3 in the same cycle as move_ready=1 → move_valid stays 1 and move_dir becomes 3.
- Reset pulsed low mid-debounce (cnt=5) and while move_valid=1 → outputs 0 immediately. Button held through reset → press 8 cycles after release.
